// File: rtl/pool_engine.sv
// pool_engine: 2x2/stride-2 signed max-pool sequencer; ports: clk/rst, start/layer in, busy/done status, pool-buffer read side (read_*), pooled output side (write_*)
module pool_engine #(
  parameter int DATSIZE = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             layer,
  output logic                   busy,
  output logic                   done,
  output logic                   read_en,
  output logic [5:0]             read_y,
  output logic [5:0]             read_x,
  output logic [5:0]             read_c,
  output logic                   read_updown,
  input  logic [2*DATSIZE-1:0]   read_data,
  output logic                   write_en,
  output logic [4:0]             write_y,
  output logic [4:0]             write_x,
  output logic [5:0]             write_c,
  output logic [DATSIZE-1:0]     write_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  logic [1:0]                r_state, r_layer;
  logic [5:0]                r_x, r_y, r_c;
  logic                      r_ud, r_rd_d, r_ud_d;
  logic [4:0]                r_d1_y, r_d1_x, r_w_y, r_w_x;
  logic [5:0]                r_d1_c, r_w_c;
  logic signed [DATSIZE-1:0] r_up_max;
  logic [5:0]                w_wmax, w_cmax;
  logic                      w_last;
  logic signed [DATSIZE-1:0] w_lo, w_hi, w_pair, w_max4;
  always_comb begin
    w_wmax = r_layer == 2'd1 ? 6'd15 : r_layer == 2'd2 ? 6'd7 : r_layer == 2'd3 ? 6'd3 : 6'd0;
    w_cmax = r_layer == 2'd1 ? 6'd15 : r_layer == 2'd2 ? 6'd31 : r_layer == 2'd3 ? 6'd63 : 6'd0;
    w_last = r_ud && r_x == w_wmax && r_y == w_wmax && r_c == w_cmax;
    w_lo   = read_data[DATSIZE-1:0];
    w_hi   = read_data[2*DATSIZE-1:DATSIZE];
    w_pair = w_lo > w_hi ? w_lo : w_hi;
    w_max4 = r_up_max > w_pair ? r_up_max : w_pair;
  end
  assign busy        = r_state == S_RUN || r_state == S_DRAIN;
  assign done        = r_state == S_DONE;
  assign read_en     = r_state == S_RUN;
  assign read_y      = r_y;
  assign read_x      = r_x;
  assign read_c      = r_c;
  assign read_updown = r_ud;
  // a down read one cycle ago means its pair is on read_data now
  assign write_en    = r_rd_d && r_ud_d;
  assign write_data  = write_en ? w_max4 : '0;
  assign write_y     = r_w_y;
  assign write_x     = r_w_x;
  assign write_c     = r_w_c;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_layer  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_c      <= '0;
      r_ud     <= 1'b0;
      r_rd_d   <= 1'b0;
      r_ud_d   <= 1'b0;
      r_up_max <= '0;
      r_d1_y   <= '0;
      r_d1_x   <= '0;
      r_d1_c   <= '0;
      r_w_y    <= '0;
      r_w_x    <= '0;
      r_w_c    <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_state <= layer == 2'd0 ? S_DONE : S_RUN;
        r_layer <= layer;
        r_x     <= '0;
        r_y     <= '0;
        r_c     <= '0;
        r_ud    <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_ud <= ~r_ud;
        // advance x, then y, then c after each down read; the last pixel wraps all to 0
        if (r_ud) begin
          r_x <= r_x == w_wmax ? 6'd0 : r_x + 6'd1;
          if (r_x == w_wmax) begin
            r_y <= r_y == w_wmax ? 6'd0 : r_y + 6'd1;
            if (r_y == w_wmax) r_c <= r_c == w_cmax ? 6'd0 : r_c + 6'd1;
          end
        end
        if (w_last) r_state <= S_DRAIN;
      end else if (r_state == S_DRAIN) begin
        r_state <= S_DONE;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
      r_rd_d <= read_en;
      r_ud_d <= r_ud;
      if (r_rd_d && !r_ud_d) r_up_max <= w_pair;
      r_d1_y <= r_y[4:0];
      r_d1_x <= r_x[4:0];
      r_d1_c <= r_c;
      r_w_y  <= r_d1_y;
      r_w_x  <= r_d1_x;
      r_w_c  <= r_d1_c;
    end
  end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed self-checking bench for pool_engine
module tb_pool_engine;
  localparam int D = 22;
  logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]     layer = 2'd0;
  logic           busy, done, read_en, read_updown, write_en;
  logic [5:0]     read_y, read_x, read_c, write_c;
  logic [4:0]     write_y, write_x;
  logic [2*D-1:0] read_data = '0;
  logic [D-1:0]   write_data;
  int checks = 0, failures = 0;
  bit ovr = 1'b0;
  int n_rd, n_wr, n_bad, done_at, max_wc, first_wr;
  logic [D-1:0] wd_first [3];

  pool_engine #(.DATSIZE(D)) dut (
    .clk(clk), .rst(rst), .start(start), .layer(layer), .busy(busy), .done(done),
    .read_en(read_en), .read_y(read_y), .read_x(read_x), .read_c(read_c),
    .read_updown(read_updown), .read_data(read_data), .write_en(write_en),
    .write_y(write_y), .write_x(write_x), .write_c(write_c), .write_data(write_data)
  );

  always #5 clk = ~clk;

  localparam logic [D-1:0] MINV = {1'b1, {(D-1){1'b0}}};

  // coordinate-encoded pairs; the position holding the max rotates with x[1:0]
  function automatic logic [2*D-1:0] model(input int y, input int x, input int c, input int ud);
    logic [D-1:0] lo, hi;
    int enc;
    enc = c * 1024 + y * 32 + x;
    lo  = D'(enc * 8 + ((ud * 2) ^ (x % 4)));
    hi  = D'(enc * 8 + ((ud * 2 + 1) ^ (x % 4)));
    if (ovr && c == 0 && y == 0 && x < 3) begin
      if (x == 0) begin
        lo = ud != 0 ? D'(7) : -D'(5);
        hi = ud != 0 ? -D'(100) : D'(3);
      end else if (x == 1) begin
        lo = ud != 0 ? -D'(3) : -D'(1);
        hi = ud != 0 ? -D'(4) : -D'(2);
      end else begin
        lo = MINV;
        hi = MINV;
      end
    end
    return {hi, lo};
  endfunction

  function automatic logic [D-1:0] exp_data(input int y, input int x, input int c);
    if (ovr && c == 0 && y == 0 && x < 3) return x == 0 ? D'(7) : x == 1 ? -D'(1) : MINV;
    return D'((c * 1024 + y * 32 + x) * 8 + 3);
  endfunction

  always @(posedge clk) read_data <= read_en ? model(read_y, read_x, read_c, read_updown) : '0;

  // starts a pass at the current negedge; ends at the negedge of the cycle after done
  task automatic run_pass(input logic [1:0] lay, input int restart_at, input int stop_at);
    int w, cm, n, k, nw;
    w  = lay == 2'd1 ? 16 : lay == 2'd2 ? 8 : 4;
    cm = lay == 2'd1 ? 16 : lay == 2'd2 ? 32 : 64;
    n  = w * w * cm;
    n_rd = 0; n_wr = 0; n_bad = 0; done_at = -1; max_wc = 0; first_wr = -1; nw = 0;
    start = 1'b1;
    layer = lay;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 2 * n + 2; t++) begin
      if (t == stop_at) return;
      if (read_en) n_rd++;
      if (read_en !== (t <= 2 * n)) n_bad++;
      else if (read_en) begin
        k = (t - 1) / 2;
        if (read_updown !== 1'((t - 1) % 2) || read_x !== 6'(k % w) ||
            read_y !== 6'((k / w) % w) || read_c !== 6'(k / (w * w))) n_bad++;
      end
      if (write_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = t;
        if (int'(write_c) > max_wc) max_wc = int'(write_c);
        if (nw < 3) wd_first[nw] = write_data;
        nw++;
      end
      if (write_en !== (t >= 3 && t <= 2 * n + 1 && t % 2 == 1)) n_bad++;
      else if (write_en) begin
        k = (t - 3) / 2;
        if (write_x !== 5'(k % w) || write_y !== 5'((k / w) % w) || write_c !== 6'(k / (w * w)) ||
            write_data !== exp_data((k / w) % w, k % w, k / (w * w))) n_bad++;
      end
      if (busy !== (t <= 2 * n + 1)) n_bad++;
      if (done) begin
        if (done_at < 0) done_at = t;
        else n_bad++;
      end
      if (t == restart_at) begin
        start = 1'b1;
        layer = 2'd1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, read_en, write_en, read_updown, read_y, read_x, read_c, write_y, write_x, write_c, write_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b rd=%b wr=%b wd=%0h required all 0", busy, done, read_en, write_en, write_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pool1();
    run_pass(2'd1, -1, -1);
    checks++; if (n_rd !== 8192) begin failures++; $display("FAIL pool1_reads got=%0d exp=8192", n_rd); end
    checks++; if (n_wr !== 4096) begin failures++; $display("FAIL pool1_writes got=%0d exp=4096", n_wr); end
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL pool1_cycle_errors got=%0d exp=0", n_bad); end
    checks++; if (done_at !== 8194) begin failures++; $display("FAIL pool1_done_cycle got=%0d exp=8194", done_at); end
    checks++; if (first_wr !== 3) begin failures++; $display("FAIL pool1_first_write got=%0d exp=3", first_wr); end
    checks++; if (max_wc !== 15) begin failures++; $display("FAIL pool1_max_c got=%0d exp=15", max_wc); end
  endtask

  task automatic test_back_to_back();
    run_pass(2'd2, -1, -1);
    checks++; if (done_at !== 4098) begin failures++; $display("FAIL pool2_done_cycle got=%0d exp=4098", done_at); end
    checks++; if (max_wc !== 31) begin failures++; $display("FAIL pool2_max_c got=%0d exp=31", max_wc); end
    checks++; if (n_bad !== 0 || n_wr !== 2048) begin failures++; $display("FAIL pool2_pass errors=%0d writes=%0d exp 0/2048", n_bad, n_wr); end
    run_pass(2'd3, -1, -1);
    checks++; if (done_at !== 2050) begin failures++; $display("FAIL pool3_done_cycle got=%0d exp=2050", done_at); end
    checks++; if (max_wc !== 63) begin failures++; $display("FAIL pool3_max_c got=%0d exp=63", max_wc); end
    checks++; if (n_bad !== 0 || n_wr !== 1024) begin failures++; $display("FAIL pool3_pass errors=%0d writes=%0d exp 0/1024", n_bad, n_wr); end
  endtask

  task automatic test_signed_max();
    ovr = 1'b1;
    run_pass(2'd3, -1, -1);
    ovr = 1'b0;
    checks++; if (wd_first[0] !== D'(7)) begin failures++; $display("FAIL smax_mixed got=%0d exp=7", $signed(wd_first[0])); end
    checks++; if (wd_first[1] !== -D'(1)) begin failures++; $display("FAIL smax_neg got=%0d exp=-1", $signed(wd_first[1])); end
    checks++; if (wd_first[2] !== MINV) begin failures++; $display("FAIL smax_min got=%0d exp=-2097152", $signed(wd_first[2])); end
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL smax_pass_errors got=%0d exp=0", n_bad); end
  endtask

  task automatic test_restart_ignored();
    run_pass(2'd3, 100, -1);
    checks++; if (done_at !== 2050) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=2050", done_at); end
    checks++; if (n_rd !== 2048 || n_wr !== 1024) begin failures++; $display("FAIL restart_counts reads=%0d writes=%0d exp 2048/1024", n_rd, n_wr); end
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL restart_errors got=%0d exp=0", n_bad); end
  endtask

  task automatic test_reset_abort();
    int spurious;
    run_pass(2'd1, -1, 500);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, read_en, write_en, read_updown, read_y, read_x, read_c, write_y, write_x, write_c, write_data} !== '0) begin
      failures++;
      $display("FAIL abort_outputs busy=%b rd=%b wr=%b x=%0d c=%0d required all 0", busy, read_en, write_en, read_x, read_c);
    end
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (done || busy || read_en || write_en) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", spurious); end
    run_pass(2'd1, -1, -1);
    checks++; if (first_wr !== 3) begin failures++; $display("FAIL post_reset_first_write got=%0d exp=3", first_wr); end
    checks++; if (done_at !== 8194 || n_bad !== 0 || n_wr !== 4096) begin
      failures++; $display("FAIL post_reset_pass done=%0d errors=%0d writes=%0d exp 8194/0/4096", done_at, n_bad, n_wr);
    end
  endtask

  task automatic test_layer0();
    int act;
    start = 1'b1;
    layer = 2'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, read_en, write_en} !== 4'b1000) begin
      failures++; $display("FAIL layer0_cycle1 done/busy/rd/wr=%b exp=1000", {done, busy, read_en, write_en});
    end
    act = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || read_en || write_en) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL layer0_after got=%0d exp=0", act); end
  endtask

  initial begin
    test_reset();
    test_pool1();
    test_back_to_back();
    test_signed_max();
    test_restart_ignored();
    test_reset_abort();
    test_layer0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
